// File: rtl/param_alu.sv
// Parameterised multi-cycle ALU: single-cycle logic/arith/shift ops plus an iterative shift-add multiplier.
// Results, flags and the Done/Err pulses commit together on the DONE->IDLE edge; Start is ignored unless Ready.
module param_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [5:0]       OP,
    input  logic [WIDTH-1:0] Value1,
    input  logic [WIDTH-1:0] Value2,
    output logic             Ready,
    output logic             Done,
    output logic             Err,
    output logic [WIDTH-1:0] ResultC,
    output logic [3:0]       Status
);

    localparam logic [5:0] OP_ADD = 6'b010000;
    localparam logic [5:0] OP_SUB = 6'b010001;
    localparam logic [5:0] OP_AND = 6'b001000;
    localparam logic [5:0] OP_OR  = 6'b001001;
    localparam logic [5:0] OP_NOR = 6'b001010;
    localparam logic [5:0] OP_XOR = 6'b001011;
    localparam logic [5:0] OP_SRL = 6'b000100;
    localparam logic [5:0] OP_SLL = 6'b000101;
    localparam logic [5:0] OP_MUL = 6'b011000;

    // The multiplier runs WIDTH add/shift steps plus one cycle to form the result and flags.
    localparam logic [SHW:0] MUL_LAST = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [SHW:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]   rslt_q, rslt_d;
    logic [3:0]         flag_q, flag_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         status_q, status_d;
    logic               done_q, done_d;
    logic               errp_q, errp_d;

    logic [WIDTH:0]     add_ext;
    logic [WIDTH-1:0]   diff;
    logic               shift_big;
    logic [WIDTH:0]     mul_hi;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_err;

    assign add_ext   = {1'b0, a_q} + {1'b0, b_q};
    assign diff      = a_q - b_q;
    assign shift_big = |b_q[WIDTH-1:SHW];
    assign mul_hi    = acc_q[2*WIDTH:WIDTH] + {1'b0, ({WIDTH{acc_q[0]}} & a_q)};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_ext[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_c   = (a_q >= b_q);
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_NOR: alu_res = ~(a_q | b_q);
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SRL: alu_res = shift_big ? '0 : (a_q >> b_q[SHW-1:0]);
            OP_SLL: alu_res = shift_big ? '0 : (a_q << b_q[SHW-1:0]);
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        rslt_d   = rslt_q;
        flag_d   = flag_q;
        err_d    = err_q;
        result_d = result_q;
        status_d = status_q;
        done_d   = 1'b0;
        errp_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d    = OP;
                    a_d     = Value1;
                    b_d     = Value2;
                    acc_d   = {{(WIDTH+1){1'b0}}, Value2};
                    cnt_d   = '0;
                    state_d = (OP == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                rslt_d  = alu_res;
                flag_d  = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
                err_d   = alu_err;
                state_d = DONE;
            end
            MUL: begin
                if (cnt_q == MUL_LAST) begin
                    rslt_d  = acc_q[WIDTH-1:0];
                    flag_d  = {acc_q[WIDTH-1], (acc_q[WIDTH-1:0] == '0),
                               (acc_q[2*WIDTH-1:WIDTH] != '0), 1'b0};
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    // Add A into the upper half when the current multiplier bit is set, then shift right.
                    acc_d = {mul_hi, acc_q[WIDTH-1:0]} >> 1;
                    cnt_d = cnt_q + (SHW+1)'(1);
                end
            end
            DONE: begin
                done_d = 1'b1;
                errp_d = err_q;
                if (!err_q) begin
                    result_d = rslt_q;
                    status_d = flag_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rslt_q   <= '0;
            flag_q   <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
            errp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            rslt_q   <= rslt_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
            result_q <= result_d;
            status_q <= status_d;
            done_q   <= done_d;
            errp_q   <= errp_d;
        end
    end

    assign Ready   = (state_q == IDLE);
    assign Done    = done_q;
    assign Err     = errp_q;
    assign ResultC = result_q;
    assign Status  = status_q;

endmodule

// File: tb/tb_param_alu.sv
// Directed plus randomized bench for param_alu (WIDTH=32) against an arithmetic reference model.
module tb_param_alu;

    localparam logic [5:0] ADD = 6'b010000;
    localparam logic [5:0] SUB = 6'b010001;
    localparam logic [5:0] AND_ = 6'b001000;
    localparam logic [5:0] OR_  = 6'b001001;
    localparam logic [5:0] NOR_ = 6'b001010;
    localparam logic [5:0] XOR_ = 6'b001011;
    localparam logic [5:0] SRL = 6'b000100;
    localparam logic [5:0] SLL = 6'b000101;
    localparam logic [5:0] MUL = 6'b011000;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [5:0]  OP;
    logic [31:0] Value1;
    logic [31:0] Value2;
    logic        Ready;
    logic        Done;
    logic        Err;
    logic [31:0] ResultC;
    logic [3:0]  Status;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_res = '0;
    logic [3:0]  exp_stat = '0;

    param_alu dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (Start),
        .OP     (OP),
        .Value1 (Value1),
        .Value2 (Value2),
        .Ready  (Ready),
        .Done   (Done),
        .Err    (Err),
        .ResultC(ResultC),
        .Status (Status)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the operation definitions.
    function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] st, output bit err);
        longint unsigned ua, ub, p;
        longint sa, sb, s;
        bit c, v;
        ua = {32'h0, a};
        ub = {32'h0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        err = 1'b0;
        r = '0;
        case (op)
            ADD: begin
                p = ua + ub; r = p[31:0]; c = p[32];
                s = sa + sb; v = (s != longint'($signed(r)));
            end
            SUB: begin
                r = a - b; c = (a >= b);
                s = sa - sb; v = (s != longint'($signed(r)));
            end
            AND_: r = a & b;
            OR_:  r = a | b;
            NOR_: r = ~(a | b);
            XOR_: r = a ^ b;
            SRL:  r = (b >= 32) ? 32'h0 : (a >> b);
            SLL:  r = (b >= 32) ? 32'h0 : (a << b);
            MUL: begin
                p = ua * ub; r = p[31:0]; c = ((p >> 32) != 0);
            end
            default: err = 1'b1;
        endcase
        st = {r[31], (r == 32'h0), c, v};
    endfunction

    // Issues one op from IDLE, scrambles inputs after accept, and checks latency, outputs and pulse width.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [31:0] er;
        logic [3:0]  es;
        bit          ee;
        int          n;
        int          lat;
        bit          seen;
        model(op, a, b, er, es, ee);
        if (!ee) begin
            exp_res  = er;
            exp_stat = es;
        end
        lat = (op == MUL) ? 34 : 2;
        chk("ready_before", Ready, 1);
        Start = 1'b1; OP = op; Value1 = a; Value2 = b;
        step();
        Start = 1'b0; OP = 6'($urandom); Value1 = $urandom; Value2 = $urandom;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            Start = (poke && n == 5);
            step();
            n++;
            if (poke && n == 6) chk("busy_not_ready", Ready, 0);
            if (Done === 1'b1) seen = 1'b1;
        end
        Start = 1'b0;
        chk("done_latency", n, lat);
        chk("result", ResultC, exp_res);
        chk("status", Status, exp_stat);
        chk("err_flag", Err, ee);
        step();
        chk("done_one_cycle", Done, 0);
        chk("err_one_cycle", Err, 0);
        chk("ready_after", Ready, 1);
    endtask

    initial begin
        logic [5:0] ops [9];
        int n;
        int idx;
        logic [5:0]  rop;
        logic [31:0] ra, rb;
        logic [31:0] er;
        logic [3:0]  es;
        bit          ee;
        ops = '{ADD, SUB, AND_, OR_, NOR_, XOR_, SRL, SLL, MUL};

        // Reset wins over a simultaneous Start.
        Reset = 1'b1; Start = 1'b1; OP = ADD; Value1 = 32'd5; Value2 = 32'd7;
        step();
        step();
        chk("rst_ready", Ready, 1);
        chk("rst_result", ResultC, 0);
        chk("rst_status", Status, 0);
        chk("rst_done", Done, 0);
        chk("rst_err", Err, 0);
        Reset = 1'b0; Start = 1'b0;
        step();
        chk("post_rst_ready", Ready, 1);

        run_op(ADD, 32'h7FFFFFFF, 32'h1, 1'b0);
        chk("add_ovf_res", ResultC, 32'h80000000);
        chk("add_ovf_stat", Status, 4'b1001);

        run_op(6'b111111, 32'h1234, 32'h5678, 1'b0);
        chk("illegal_keeps_res", ResultC, 32'h80000000);
        chk("illegal_keeps_stat", Status, 4'b1001);

        run_op(SUB, 32'd5, 32'd5, 1'b0);
        chk("sub_eq_res", ResultC, 32'h0);
        chk("sub_eq_stat", Status, 4'b0110);
        run_op(SUB, 32'd0, 32'd1, 1'b0);
        chk("sub_borrow_res", ResultC, 32'hFFFFFFFF);
        chk("sub_borrow_stat", Status, 4'b1000);

        run_op(SLL, 32'h1, 32'd31, 1'b0);
        chk("sll31_res", ResultC, 32'h80000000);
        chk("sll31_stat", Status, 4'b1000);
        run_op(SRL, 32'hF0000000, 32'd40, 1'b0);
        chk("srl40_res", ResultC, 32'h0);
        chk("srl40_stat", Status, 4'b0100);

        run_op(MUL, 32'h10000, 32'h10000, 1'b1);
        chk("mul_res", ResultC, 32'h0);
        chk("mul_stat", Status, 4'b0110);

        // Reset ten cycles into a multiply: the op is abandoned silently.
        Start = 1'b1; OP = MUL; Value1 = 32'h1234; Value2 = 32'h5678;
        step();
        Start = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (Done === 1'b1) n++;
        end
        chk("mul_no_early_done", n, 0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("midrst_ready", Ready, 1);
        chk("midrst_result", ResultC, 0);
        chk("midrst_status", Status, 0);
        chk("midrst_done", Done, 0);
        exp_res = '0;
        exp_stat = '0;
        step();
        chk("midrst_no_done", Done, 0);
        run_op(XOR_, 32'hFF, 32'h0F, 1'b0);
        chk("xor_res", ResultC, 32'hF0);
        chk("xor_stat", Status, 4'b0000);

        // Start held high: next accept on the first IDLE cycle, so Done repeats every 3 cycles.
        model(OR_, 32'hA5A50000, 32'h00005A5A, er, es, ee);
        exp_res = er;
        exp_stat = es;
        Start = 1'b1; OP = OR_; Value1 = 32'hA5A50000; Value2 = 32'h00005A5A;
        n = 0;
        do begin step(); n++; end while (Done !== 1'b1 && n < 20);
        chk("hold_first_done", n, 3);
        n = 0;
        do begin step(); n++; end while (Done !== 1'b1 && n < 20);
        chk("hold_period", n, 3);
        Start = 1'b0;
        chk("hold_res", ResultC, exp_res);
        chk("hold_stat", Status, exp_stat);
        step();
        chk("hold_stop_ready", Ready, 1);

        for (int k = 0; k < 40; k++) begin
            idx = $urandom_range(0, 9);
            rop = (idx == 9) ? 6'($urandom_range(0, 63)) : ops[idx];
            ra = $urandom;
            rb = $urandom;
            if (rop == SRL || rop == SLL) rb = $urandom_range(0, 40);
            if (k % 7 == 3) rb = ra;
            if (k % 11 == 5) ra = 32'h80000000;
            run_op(rop, ra, rb, (k % 5 == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width; legal values 8..64, powers of two.
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount field width.
REQ-003 Port: Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: Reset  input  1  synchronous, active-high reset.
REQ-005 Port: Start  input  1  request; accepted on a rising edge where Start=1 and Ready=1.
REQ-006 Port: OP  input  6  operation code, sampled at accept.
REQ-007 Port: Value1  input  WIDTH  operand A, sampled at accept.
REQ-008 Port: Value2  input  WIDTH  operand B, sampled at accept.
REQ-009 Port: Ready  output  1  high in IDLE only.
REQ-010 Port: Done  output  1  one-cycle pulse when ResultC/Status are updated.
REQ-011 Port: Err  output  1  one-cycle pulse, coincident with Done, for an illegal OP.
REQ-012 Port: ResultC  output  WIDTH  registered result; holds until the next Done.
REQ-013 Port: Status  output  4  registered flags {N,Z,C,V} = bits [3:0]; hold until the next Done.

Function
REQ-014 Opcodes: 010000 ADD, 010001 SUB, 001000 AND, 001001 OR, 001010 NOR, 001011 XOR, 000100 SRL, 000101 SLL, 011000 MUL; all other codes are illegal.
REQ-015 FSM states: IDLE, EXEC, MUL, DONE; IDLE->EXEC on accept of a non-MUL op, IDLE->MUL on accept of MUL, EXEC->DONE, MUL->DONE after WIDTH iterations, DONE->IDLE unconditionally.
REQ-016 Operands and OP are latched at accept; input changes after accept have no effect on the operation in flight.
REQ-017 Single-cycle ops: Done is asserted 2 cycles after the accept edge; total throughput is one op per 3 cycles.
REQ-018 MUL: iterative shift-add, one bit of Value2 per cycle; Done is asserted WIDTH+2 cycles after accept.
REQ-019 ADD: ResultC = A+B mod 2^WIDTH; C = carry out; V = signed overflow.
REQ-020 SUB: ResultC = A-B mod 2^WIDTH; C = 1 when A>=B unsigned (no borrow); V = signed overflow.
REQ-021 AND/OR/NOR/XOR: bitwise; C=0, V=0.
REQ-022 SRL/SLL: logical shift of A by B[SHW-1:0]; if B >= WIDTH, ResultC = 0; C=0, V=0.
REQ-023 MUL: ResultC = low WIDTH bits of A*B unsigned; C = 1 when the high WIDTH bits are nonzero; V=0.
REQ-024 Every legal op: N = ResultC[WIDTH-1], Z = (ResultC==0).
REQ-025 Illegal OP: takes the EXEC path; Done and Err pulse; ResultC and Status are unchanged.
REQ-026 Start while Ready=0 is ignored and is not queued.
REQ-027 Start held high continuously: a new op is accepted on the first cycle back in IDLE.

Reset
REQ-028 Reset=1 at an edge forces IDLE, ResultC=0, Status=0, Done=0, Err=0, and clears internal operand and accumulator registers.
REQ-029 Reset during EXEC, MUL or DONE aborts the operation with no Done pulse; Ready=1 on the cycle after Reset deasserts.
REQ-030 Reset has priority over Start on the same edge.

Verification
REQ-031 Test ADD, WIDTH=32: A=0x7FFFFFFF, B=1 -> ResultC=0x80000000, Status=1001 (N,V); Done pulses 2 cycles after accept.
REQ-032 Test SUB: A=5, B=5 -> ResultC=0, Status=0110 (Z,C); then A=0, B=1 -> ResultC=0xFFFFFFFF, Status=1000.
REQ-033 Test shifts: SLL with A=1, B=31 -> 0x80000000, Status=1000; SRL with A=0xF0000000, B=40 -> 0, Status=0100.
REQ-034 Test MUL: A=0x10000, B=0x10000 -> ResultC=0, Status=0110, Done exactly 34 cycles after accept; a Start pulsed mid-run is ignored.
REQ-035 Test illegal OP=111111 after an ADD -> Done=1 and Err=1 for one cycle; ResultC and Status keep their ADD values.
REQ-036 Test reset mid-MUL at cycle 10 -> no Done; ResultC=0, Status=0, Ready=1 on the next cycle; a following XOR with A=0xFF, B=0x0F -> ResultC=0xF0, Status=0000.
